// File: rtl/matrix_slot_manager.sv
// Slot-table allocator: alloc/commit handshake, per-slot FREE/RESERVED/VALID state, query port, valid mask.
// Optional feature macro MATRIX_MGR_EVICT_EN: a full table evicts slot replace_ptr instead of failing.
module matrix_slot_manager #(
    parameter int unsigned NUM_SLOTS  = 8,
    parameter int unsigned SLOT_SIZE  = 256,
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_req,
    output logic                  alloc_valid,
    output logic [3:0]            alloc_slot,
    output logic [ADDR_WIDTH-1:0] alloc_addr,
    output logic                  alloc_fail,
    input  logic                  commit_req,
    input  logic [3:0]            commit_slot,
    input  logic [4:0]            commit_m,
    input  logic [4:0]            commit_n,
    input  logic [ADDR_WIDTH-1:0] commit_addr,
    output logic                  commit_err,
    input  logic                  clear_all,
    input  logic [3:0]            query_slot,
    output logic                  query_valid,
    output logic [4:0]            query_m,
    output logic [4:0]            query_n,
    output logic [ADDR_WIDTH-1:0] query_addr,
    output logic [NUM_SLOTS-1:0]  slot_valid_mask,
    output logic [4:0]            num_valid
);
    localparam int unsigned SLOT_SHIFT = $clog2(SLOT_SIZE);
    localparam int unsigned IDX_W      = $clog2(NUM_SLOTS);

    typedef enum logic [1:0] {ST_FREE = 2'd0, ST_RESERVED = 2'd1, ST_VALID = 2'd2} slot_state_e;
    typedef struct packed {
        slot_state_e st;
        logic [4:0]  m;
        logic [4:0]  n;
    } slot_rec_t;
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FULL = 2'd2, GRANT = 2'd3} fsm_e;

    localparam slot_rec_t REC_FREE = '{st: ST_FREE, m: 5'd0, n: 5'd0};

    fsm_e                  state_q, state_d;
    slot_rec_t             tbl_q [NUM_SLOTS];
    slot_rec_t             tbl_d [NUM_SLOTS];
    logic [3:0]            scan_idx_q, scan_idx_d;
    logic [3:0]            grant_idx_q, grant_idx_d;
    logic [3:0]            replace_ptr_q, replace_ptr_d;
    logic                  armed_q, armed_d;
    logic                  alloc_valid_d, alloc_fail_d, commit_err_d, query_valid_d;
    logic [3:0]            alloc_slot_d;
    logic [ADDR_WIDTH-1:0] alloc_addr_d, query_addr_d;
    logic [4:0]            query_m_d, query_n_d, num_valid_d;
    logic [NUM_SLOTS-1:0]  mask_d;
    logic                  commit_in_range, commit_ok, scan_free;

    function automatic logic [ADDR_WIDTH-1:0] base_of(input logic [3:0] slot);
        return ADDR_WIDTH'(32'(slot) << SLOT_SHIFT);
    endfunction

    // Next-state, table update and registered-output values
    always_comb begin
        state_d       = state_q;
        scan_idx_d    = scan_idx_q;
        grant_idx_d   = grant_idx_q;
        replace_ptr_d = replace_ptr_q;
        armed_d       = armed_q;
        tbl_d         = tbl_q;
        alloc_valid_d = 1'b0;
        alloc_slot_d  = 4'd0;
        alloc_addr_d  = '0;
        alloc_fail_d  = 1'b0;
        commit_err_d  = 1'b0;
        query_valid_d = 1'b0;
        query_m_d     = 5'd0;
        query_n_d     = 5'd0;
        query_addr_d  = '0;
        mask_d        = '0;
        num_valid_d   = 5'd0;
        scan_free     = 1'b0;
        commit_ok     = 1'b0;

        commit_in_range = 32'(commit_slot) < NUM_SLOTS;
        if (commit_req && commit_in_range) begin
            commit_ok = (tbl_q[commit_slot[IDX_W-1:0]].st == ST_RESERVED)
                     && (commit_m >= 5'd1) && (commit_m <= 5'd16)
                     && (commit_n >= 5'd1) && (commit_n <= 5'd16)
                     && (commit_addr == base_of(commit_slot));
        end

        if (!alloc_req) armed_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (alloc_req && armed_q) begin
                    scan_idx_d = 4'd0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                // Uncommitted reservations count as free; a same-cycle commit makes the slot VALID
                scan_free = (tbl_q[scan_idx_q[IDX_W-1:0]].st != ST_VALID)
                         && !(commit_ok && (commit_slot == scan_idx_q));
                if (scan_free) begin
                    grant_idx_d = scan_idx_q;
                    state_d     = GRANT;
                end else if (scan_idx_q == 4'(NUM_SLOTS - 1)) begin
                    state_d = FULL;
                end else begin
                    scan_idx_d = scan_idx_q + 4'd1;
                end
            end
            GRANT: begin
                for (int i = 0; i < NUM_SLOTS; i++)
                    if (tbl_q[i].st == ST_RESERVED) tbl_d[i].st = ST_FREE;
                tbl_d[grant_idx_q[IDX_W-1:0]].st = ST_RESERVED;
                alloc_valid_d = 1'b1;
                alloc_slot_d  = grant_idx_q;
                alloc_addr_d  = base_of(grant_idx_q);
                armed_d       = 1'b0;
                state_d       = IDLE;
            end
            FULL: begin
`ifdef MATRIX_MGR_EVICT_EN
                for (int i = 0; i < NUM_SLOTS; i++)
                    if (tbl_q[i].st == ST_RESERVED) tbl_d[i].st = ST_FREE;
                tbl_d[replace_ptr_q[IDX_W-1:0]].st = ST_RESERVED;
                alloc_valid_d = 1'b1;
                alloc_slot_d  = replace_ptr_q;
                alloc_addr_d  = base_of(replace_ptr_q);
                replace_ptr_d = (replace_ptr_q == 4'(NUM_SLOTS - 1)) ? 4'd0 : replace_ptr_q + 4'd1;
`else
                alloc_fail_d  = 1'b1;
`endif
                armed_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (commit_ok) begin
            tbl_d[commit_slot[IDX_W-1:0]] = '{st: ST_VALID, m: commit_m, n: commit_n};
            replace_ptr_d = (commit_slot == 4'(NUM_SLOTS - 1)) ? 4'd0 : commit_slot + 4'd1;
        end else if (commit_req) begin
            commit_err_d = 1'b1;
        end

        // clear_all cancels any in-flight allocation and same-cycle commit
        if (clear_all) begin
            for (int i = 0; i < NUM_SLOTS; i++) tbl_d[i] = REC_FREE;
            state_d       = IDLE;
            replace_ptr_d = 4'd0;
            alloc_valid_d = 1'b0;
            alloc_slot_d  = 4'd0;
            alloc_addr_d  = '0;
            commit_err_d  = 1'b0;
            alloc_fail_d  = (state_q != IDLE);
            if (state_q != IDLE) armed_d = 1'b0;
        end

        if (32'(query_slot) < NUM_SLOTS) begin
            query_valid_d = tbl_q[query_slot[IDX_W-1:0]].st == ST_VALID;
            query_m_d     = tbl_q[query_slot[IDX_W-1:0]].m;
            query_n_d     = tbl_q[query_slot[IDX_W-1:0]].n;
            query_addr_d  = base_of(query_slot);
        end

        for (int i = 0; i < NUM_SLOTS; i++) begin
            mask_d[i]   = tbl_q[i].st == ST_VALID;
            num_valid_d = num_valid_d + 5'(mask_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            scan_idx_q      <= 4'd0;
            grant_idx_q     <= 4'd0;
            replace_ptr_q   <= 4'd0;
            armed_q         <= 1'b1;
            for (int i = 0; i < NUM_SLOTS; i++) tbl_q[i] <= REC_FREE;
            alloc_valid     <= 1'b0;
            alloc_slot      <= 4'd0;
            alloc_addr      <= '0;
            alloc_fail      <= 1'b0;
            commit_err      <= 1'b0;
            query_valid     <= 1'b0;
            query_m         <= 5'd0;
            query_n         <= 5'd0;
            query_addr      <= '0;
            slot_valid_mask <= '0;
            num_valid       <= 5'd0;
        end else begin
            state_q         <= state_d;
            scan_idx_q      <= scan_idx_d;
            grant_idx_q     <= grant_idx_d;
            replace_ptr_q   <= replace_ptr_d;
            armed_q         <= armed_d;
            tbl_q           <= tbl_d;
            alloc_valid     <= alloc_valid_d;
            alloc_slot      <= alloc_slot_d;
            alloc_addr      <= alloc_addr_d;
            alloc_fail      <= alloc_fail_d;
            commit_err      <= commit_err_d;
            query_valid     <= query_valid_d;
            query_m         <= query_m_d;
            query_n         <= query_n_d;
            query_addr      <= query_addr_d;
            slot_valid_mask <= mask_d;
            num_valid       <= num_valid_d;
        end
    end
endmodule

// File: tb/tb_matrix_slot_manager.sv
// Directed + randomized bench for matrix_slot_manager against a transaction-level slot-table model.
// Honours MATRIX_MGR_EVICT_EN for the full-table expectation.
module tb_matrix_slot_manager;
    localparam int N  = 8;
    localparam int SS = 256;
    localparam int AW = 11;

    logic          clk, rst_n;
    logic          alloc_req, alloc_valid, alloc_fail;
    logic [3:0]    alloc_slot;
    logic [AW-1:0] alloc_addr;
    logic          commit_req, commit_err;
    logic [3:0]    commit_slot;
    logic [4:0]    commit_m, commit_n;
    logic [AW-1:0] commit_addr;
    logic          clear_all;
    logic [3:0]    query_slot;
    logic          query_valid;
    logic [4:0]    query_m, query_n;
    logic [AW-1:0] query_addr;
    logic [N-1:0]  slot_valid_mask;
    logic [4:0]    num_valid;

    matrix_slot_manager #(.NUM_SLOTS(N), .SLOT_SIZE(SS), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_slot(alloc_slot),
        .alloc_addr(alloc_addr), .alloc_fail(alloc_fail),
        .commit_req(commit_req), .commit_slot(commit_slot), .commit_m(commit_m),
        .commit_n(commit_n), .commit_addr(commit_addr), .commit_err(commit_err),
        .clear_all(clear_all), .query_slot(query_slot), .query_valid(query_valid),
        .query_m(query_m), .query_n(query_n), .query_addr(query_addr),
        .slot_valid_mask(slot_valid_mask), .num_valid(num_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: 0 = free, 1 = reserved, 2 = valid
    int mst [16];
    int mm  [16];
    int mn  [16];
    int rptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int base(input int slot);
        return (slot * SS) % (1 << AW);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin mst[i] = 0; mm[i] = 0; mn[i] = 0; end
        rptr = 0;
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] r = 0;
        for (int i = 0; i < N; i++) if (mst[i] == 2) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] model_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (mst[i] == 2) c++;
        return 32'(c);
    endfunction

    task automatic chk_mask(input string tag);
        chk({tag, "_mask"}, 32'(slot_valid_mask), model_mask());
        chk({tag, "_num"}, 32'(num_valid), model_count());
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {alloc_valid, alloc_fail, commit_err, query_valid}, 0);
        chk({tag, "_alloc"}, {alloc_slot, alloc_addr}, 0);
        chk({tag, "_query"}, {query_m, query_n, query_addr}, 0);
        chk({tag, "_mask"}, {slot_valid_mask, num_valid}, 0);
    endtask

    // Request held until the response plus one extra cycle; no second response may follow
    task automatic do_alloc(input string tag);
        int cyc, exp_slot, exp_lat;
        bit exp_fail, seen_v, seen_f;
        logic [3:0] got_slot;
        logic [AW-1:0] got_addr;
        exp_slot = -1;
        exp_fail = 1'b0;
        for (int i = 0; i < N; i++) if (mst[i] != 2 && exp_slot < 0) exp_slot = i;
        if (exp_slot >= 0) exp_lat = exp_slot + 3;
        else begin
            exp_lat = N + 2;
`ifdef MATRIX_MGR_EVICT_EN
            exp_slot = rptr;
`else
            exp_fail = 1'b1;
`endif
        end
        @(negedge clk);
        alloc_req = 1'b1;
        cyc = 0; seen_v = 0; seen_f = 0; got_slot = '0; got_addr = '0;
        while (!seen_v && !seen_f && cyc < 64) begin
            @(negedge clk);
            cyc++;
            seen_v = alloc_valid; seen_f = alloc_fail;
            got_slot = alloc_slot; got_addr = alloc_addr;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_kind"}, {seen_f, seen_v}, exp_fail ? 2'b10 : 2'b01);
        if (!exp_fail) begin
            chk({tag, "_slot"}, 32'(got_slot), 32'(exp_slot));
            chk({tag, "_addr"}, 32'(got_addr), 32'(base(exp_slot)));
        end
        @(negedge clk);
        chk({tag, "_pulse"}, {alloc_valid, alloc_fail}, 0);
        alloc_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk({tag, "_nodup"}, {alloc_valid, alloc_fail}, 0);
        end
        if (!exp_fail) begin
            for (int i = 0; i < N; i++) if (mst[i] == 1) mst[i] = 0;
            if (mst[exp_slot] == 2) rptr = (rptr + 1) % N;
            mst[exp_slot] = 1;
        end
    endtask

    task automatic do_commit(input string tag, input int slot, input int m, input int n, input int addr);
        bit ok;
        ok = (slot < N) && (mst[slot] == 1) && (m >= 1) && (m <= 16) && (n >= 1) && (n <= 16)
             && (addr == base(slot));
        @(negedge clk);
        commit_req = 1'b1; commit_slot = 4'(slot); commit_m = 5'(m); commit_n = 5'(n);
        commit_addr = AW'(addr);
        @(negedge clk);
        commit_req = 1'b0;
        chk({tag, "_err"}, 32'(commit_err), 32'(!ok));
        if (ok) begin
            mst[slot] = 2; mm[slot] = m; mn[slot] = n; rptr = (slot + 1) % N;
        end
        @(negedge clk);
        chk_mask(tag);
    endtask

    task automatic do_query(input string tag, input int slot);
        @(negedge clk);
        query_slot = 4'(slot);
        @(negedge clk);
        if (slot >= N) begin
            chk({tag, "_oob"}, {query_valid, query_m, query_n, query_addr}, 0);
        end else if (mst[slot] == 2) begin
            chk({tag, "_qv"}, 32'(query_valid), 1);
            chk({tag, "_qmn"}, {query_m, query_n}, 32'({5'(mm[slot]), 5'(mn[slot])}));
            chk({tag, "_qaddr"}, 32'(query_addr), 32'(base(slot)));
        end else begin
            chk({tag, "_qv"}, 32'(query_valid), 0);
        end
    endtask

    task automatic clear_idle(input string tag);
        @(negedge clk);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        chk({tag, "_nofail"}, 32'(alloc_fail), 0);
        model_reset();
        @(negedge clk);
        chk_mask(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, m, n, a, res;
        rst_n = 1'b0; alloc_req = 1'b0; commit_req = 1'b0; commit_slot = '0; commit_m = '0;
        commit_n = '0; commit_addr = '0; clear_all = 1'b0; query_slot = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        do_alloc("first");
        do_commit("c0", 0, 3, 4, 0);
        do_query("q0", 0);
        do_commit("bad_m", 0, 17, 4, 0);
        do_commit("bad_addr", 0, 3, 4, 5);
        do_commit("free2", 2, 3, 4, base(2));
        do_query("q_oob", 9);

        for (int i = 1; i < N; i++) begin
            do_alloc("fill");
            do_commit("fillc", i, $urandom_range(1, 16), $urandom_range(1, 16), base(i));
        end
        do_alloc("full");
        chk_mask("after_full");

        clear_idle("clr");
        do_alloc("ab0");
        do_commit("ab0c", 0, 2, 2, 0);
        do_alloc("ab1");
        do_alloc("reclaim");

        for (int it = 0; it < 48; it++) begin
            case ($urandom_range(0, 3))
                0: do_alloc("r_alloc");
                1: begin
                    res = -1;
                    for (int i = 0; i < N; i++) if (mst[i] == 1) res = i;
                    s = (res >= 0) ? res : $urandom_range(0, N - 1);
                    m = $urandom_range(0, 18); n = $urandom_range(0, 18);
                    a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) : base(s);
                    do_commit("r_commit", s, m, n, a);
                end
                2: do_commit("r_any", $urandom_range(0, 15), $urandom_range(0, 31),
                             $urandom_range(0, 31), base($urandom_range(0, 15)));
                default: do_query("r_query", $urandom_range(0, 15));
            endcase
        end

        clear_idle("pre_scan");
        for (int i = 0; i < 3; i++) begin
            do_alloc("scan_fill");
            do_commit("scan_fillc", i, 1 + i, 16 - i, base(i));
        end
        @(negedge clk); alloc_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear_all = 1'b1; alloc_req = 1'b0;
        @(negedge clk);
        clear_all = 1'b0;
        chk("clr_scan_fail", {alloc_fail, alloc_valid}, 2'b10);
        model_reset();
        @(negedge clk);
        chk_mask("clr_scan");
        chk("clr_scan_pulse", 32'(alloc_fail), 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("clr_scan_idle", {alloc_valid, alloc_fail}, 0);
        end
        do_alloc("post_clear");

        do_commit("rst_c0", 0, 5, 6, 0);
        do_alloc("rst_a1");
        do_query("rst_q0", 0);
        @(negedge clk); alloc_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_scan");
        alloc_req = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        do_alloc("after_rst");
        chk_mask("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
